// File: rtl/apb_fll_cfg.sv
// apb_fll_cfg
//
// APB slave that bridges the peripheral bus to the FLL configuration port of
// the clock/reset generator. An access to one of the four FLL registers becomes
// a four-phase req/ack handshake on the fll_* port. A local STATUS register
// reports a synchronised lock flag and a sticky handshake-timeout flag.
//
// Address map (PADDR[4:2]):
//   0..3  FLL register, index PADDR[3:2]
//   4     STATUS: bit0 lock (RO), bit1 timeout flag (write 1 to clear)
//   5..7  unmapped: completes at once with PSLVERR=1, PRDATA=0
//
// Ports:
//   clk_i           system clock, also the FLL reference clock
//   rst_i           synchronous active-high reset
//   PADDR..PENABLE  APB request (address, write data, direction, select, enable)
//   PRDATA          APB read data
//   PREADY          APB ready, low while an FLL handshake is in progress
//   PSLVERR         APB error (handshake timeout or unmapped address)
//   fll_req_o       FLL request, registered
//   fll_wrn_o       FLL direction, 1 = read, 0 = write, registered
//   fll_add_o       FLL register index, registered
//   fll_data_o      FLL write data, registered
//   fll_ack_i       FLL acknowledge, synchronous to clk_i
//   fll_r_data_i    FLL read data, valid while fll_ack_i is high
//   fll_lock_i      FLL lock, asynchronous
module apb_fll_cfg #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      fll_req_o,
  output logic                      fll_wrn_o,
  output logic [1:0]                fll_add_o,
  output logic [31:0]               fll_data_o,
  input  logic                      fll_ack_i,
  input  logic [31:0]               fll_r_data_i,
  input  logic                      fll_lock_i
);

  // Last counter value allowed in a wait state; reaching it aborts the access.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRelease,
    StDone
  } state_e;

  state_e      state_q;
  logic [15:0] counter_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        timeout_sticky_q;
  logic        lock_meta_q;
  logic        lock_sync_q;

  logic [2:0]  reg_sel;
  logic        idle_access;
  logic        fll_access;
  logic        status_access;
  logic        unmapped_access;
  logic        status_clear;
  logic        wait_expired;
  logic        unused_paddr;

  // Only PADDR[4:2] is decoded.
  assign reg_sel      = PADDR[4:2];
  assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  // Accesses are only decoded in IDLE; elsewhere the master is holding a
  // pending FLL access stable and must not be re-decoded.
  assign idle_access     = PSEL & PENABLE & (state_q == StIdle);
  assign fll_access      = idle_access & ~reg_sel[2];
  assign status_access   = idle_access & (reg_sel == 3'd4);
  assign unmapped_access = idle_access & reg_sel[2] & (reg_sel[1:0] != 2'd0);
  assign status_clear    = status_access & PWRITE & PWDATA[1];
  assign wait_expired    = (counter_q == TimeoutLast);

  // Two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= fll_lock_i;
      lock_sync_q <= lock_meta_q;
    end
  end

  // Handshake FSM with its registered FLL outputs and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= StIdle;
      counter_q        <= '0;
      rdata_q          <= '0;
      err_q            <= 1'b0;
      timeout_sticky_q <= 1'b0;
      fll_req_o        <= 1'b0;
      fll_wrn_o        <= 1'b0;
      fll_add_o        <= '0;
      fll_data_o       <= '0;
    end else begin
      if (status_clear) begin
        timeout_sticky_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (fll_access) begin
            fll_wrn_o  <= ~PWRITE;
            fll_add_o  <= PADDR[3:2];
            fll_data_o <= PWDATA;
            fll_req_o  <= 1'b1;
            err_q      <= 1'b0;
            counter_q  <= '0;
            state_q    <= StReq;
          end
        end
        StReq: begin
          // A completed handshake takes priority over an expiring counter.
          if (fll_ack_i) begin
            if (fll_wrn_o) begin
              rdata_q <= fll_r_data_i;
            end
            fll_req_o <= 1'b0;
            counter_q <= '0;
            state_q   <= StRelease;
          end else if (wait_expired) begin
            // Assigned after the clear above so a coincident set wins.
            fll_req_o        <= 1'b0;
            rdata_q          <= '0;
            err_q            <= 1'b1;
            timeout_sticky_q <= 1'b1;
            state_q          <= StDone;
          end else begin
            counter_q <= counter_q + 16'd1;
          end
        end
        StRelease: begin
          if (!fll_ack_i) begin
            state_q <= StDone;
          end else if (wait_expired) begin
            fll_req_o        <= 1'b0;
            rdata_q          <= '0;
            err_q            <= 1'b1;
            timeout_sticky_q <= 1'b1;
            state_q          <= StDone;
          end else begin
            counter_q <= counter_q + 16'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // APB response. FLL accesses complete from DONE; local accesses complete in
  // the IDLE access cycle. Everything is held low while reset is asserted.
  always_comb begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    if (!rst_i) begin
      if (state_q == StDone) begin
        PREADY  = 1'b1;
        PSLVERR = err_q;
        if (fll_wrn_o) begin
          PRDATA = rdata_q;
        end
      end else if (status_access) begin
        PREADY = 1'b1;
        if (!PWRITE) begin
          PRDATA = {30'd0, timeout_sticky_q, lock_sync_q};
        end
      end else if (unmapped_access) begin
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_fll_cfg.sv
// Self-checking bench for apb_fll_cfg. The stimulus process issues APB
// accesses and pushes the expected APB response (and, for FLL accesses, the
// expected FLL request) into queues. A monitor pops APB responses whenever
// PREADY rises; an FLL responder model pops expected requests, answers with a
// randomised ack timing and keeps its own copy of the FLL registers.
module tb_apb_fll_cfg;

  localparam int unsigned T = 16;

  typedef enum int {ModeNormal, ModeNoAck, ModeStuck} mode_e;
  typedef enum logic [1:0] {KLocal, KFll, KReqTo, KRelTo} kind_e;
  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
    kind_e       kind;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        fll_req;
  logic        fll_wrn;
  logic [1:0]  fll_add;
  logic [31:0] fll_data;
  logic        fll_ack;
  logic [31:0] fll_r_data;
  logic        fll_lock = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          ack_rise_cyc = 0;
  int          ack_fall_cyc = 0;
  int          d1_force = -1;
  int          d2_force = -1;
  mode_e       mode = ModeNormal;
  logic        lock_on_setup = 1'b0;
  logic        lock_val = 1'b0;

  // Reference model state
  logic [31:0] ref_regs [4];
  logic        ref_sticky = 1'b0;
  logic        ref_lock = 1'b0;
  // FLL-side register file, written only from what the DUT presents
  logic [31:0] fll_mem [4];

  exp_t        sb [$];
  logic [34:0] exp_req_q [$];

  apb_fll_cfg #(
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PWRITE      (PWRITE),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .fll_req_o   (fll_req),
    .fll_wrn_o   (fll_wrn),
    .fll_add_o   (fll_add),
    .fll_data_o  (fll_data),
    .fll_ack_i   (fll_ack),
    .fll_r_data_i(fll_r_data),
    .fll_lock_i  (fll_lock)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One complete APB transfer; expectations come from the reference model.
  task automatic apb_access(input logic wr, input logic [11:0] addr, input logic [31:0] wdata);
    exp_t       e;
    logic [2:0] sel;
    logic       got;
    sel      = addr[4:2];
    e.rdata  = '0;
    e.slverr = 1'b0;
    e.kind   = KLocal;
    if (!sel[2]) begin
      exp_req_q.push_back({~wr, sel[1:0], wdata});
      if (mode == ModeNormal) begin
        e.kind = KFll;
        if (wr) ref_regs[sel[1:0]] = wdata;
        else    e.rdata = ref_regs[sel[1:0]];
      end else begin
        e.kind     = (mode == ModeNoAck) ? KReqTo : KRelTo;
        e.slverr   = 1'b1;
        ref_sticky = 1'b1;
        // A stuck ack still delivered the write to the FLL before the abort.
        if (wr && mode == ModeStuck) ref_regs[sel[1:0]] = wdata;
      end
    end else if (sel == 3'd4) begin
      if (wr) begin
        if (wdata[1]) ref_sticky = 1'b0;
      end else begin
        e.rdata = {30'd0, ref_sticky, ref_lock};
      end
    end else begin
      e.slverr = 1'b1;
    end

    @(posedge clk); #1;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    if (lock_on_setup) begin
      fll_lock      = lock_val;
      lock_on_setup = 1'b0;
    end
    @(posedge clk); #1;
    PENABLE = 1'b1;
    acc_cyc = cyc;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (PREADY) begin
        got = 1'b1;
        break;
      end
    end
    check("pready_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWDATA  = $urandom;
  endtask

  // APB response monitor
  exp_t mon_e;
  int   mon_cyc;
  always @(negedge clk) begin
    if (!rst_i && PREADY) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready: got PREADY=1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("prdata", 64'(PRDATA), 64'(mon_e.rdata));
        check("pslverr", 64'(PSLVERR), 64'(mon_e.slverr));
        case (mon_e.kind)
          KLocal:  mon_cyc = acc_cyc;
          KFll:    mon_cyc = ack_fall_cyc + 1;
          KReqTo:  mon_cyc = acc_cyc + 1 + T;
          default: mon_cyc = ack_rise_cyc + 1 + T;
        endcase
        check("pready_cycle", 64'(cyc), 64'(mon_cyc));
      end
    end
  end

  // FLL responder model
  initial begin : responder
    int          d;
    logic        got;
    logic [34:0] req_exp;
    fll_ack    = 1'b1;
    fll_r_data = '0;
    while (rst_i) @(negedge clk);
    fll_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_i && fll_req) begin
        check("req_rise_cycle", 64'(cyc), 64'(acc_cyc + 1));
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got fll_req_o=1 expected 0 (cycle %0d)", cyc);
        end else begin
          req_exp = exp_req_q.pop_front();
          check("fll_req_fields", 64'({fll_wrn, fll_add, fll_data}), 64'(req_exp));
        end
        if (mode == ModeNoAck) begin
          got = 1'b0;
          for (int i = 0; i < 3 * T; i++) begin
            @(negedge clk);
            if (!fll_req) begin
              got = 1'b1;
              break;
            end
          end
          check("noack_req_fall_cycle", got ? 64'(cyc) : '1, 64'(acc_cyc + 1 + T));
        end else begin
          d = (d1_force >= 0) ? d1_force : int'($urandom_range(0, 4));
          repeat (d) begin
            @(posedge clk); #1;
          end
          fll_ack      = 1'b1;
          ack_rise_cyc = cyc;
          if (fll_wrn) begin
            fll_r_data = fll_mem[fll_add];
          end else begin
            fll_mem[fll_add] = fll_data;
            fll_r_data       = $urandom;
          end
          got = 1'b0;
          for (int i = 0; i < 3 * T; i++) begin
            @(negedge clk);
            if (!fll_req) begin
              got = 1'b1;
              break;
            end
          end
          check("req_fall_cycle", got ? 64'(cyc) : '1, 64'(ack_rise_cyc + 1));
          if (mode == ModeStuck) begin
            for (int i = 0; i < 3 * T; i++) begin
              if (PREADY) break;
              @(negedge clk);
            end
            fll_ack = 1'b0;
          end else begin
            d = (d2_force >= 0) ? d2_force : int'($urandom_range(0, 4));
            repeat (d) begin
              @(posedge clk); #1;
            end
            fll_ack      = 1'b0;
            ack_fall_cyc = cyc;
          end
          fll_r_data = $urandom;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [2:0]  sel;
    logic        wr;
    int          r;
    for (int i = 0; i < 4; i++) begin
      ref_regs[i] = $urandom;
      fll_mem[i]  = ref_regs[i];
    end
    ref_regs[1] = 32'h1234_5678;
    fll_mem[1]  = 32'h1234_5678;

    // Reset with a STATUS access and ack both asserted: nothing may respond.
    PSEL    = 1'b1;
    PENABLE = 1'b1;
    PADDR   = 12'h010;
    PWRITE  = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_pready", 64'(PREADY), 64'd0);
      check("rst_pslverr", 64'(PSLVERR), 64'd0);
      check("rst_prdata", 64'(PRDATA), 64'd0);
      check("rst_fll_req", 64'(fll_req), 64'd0);
      check("rst_fll_wrn", 64'(fll_wrn), 64'd0);
      check("rst_fll_add", 64'(fll_add), 64'd0);
      check("rst_fll_data", 64'(fll_data), 64'd0);
    end
    @(posedge clk); #1;
    rst_i   = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;

    apb_access(1'b0, 12'h010, 32'h0);

    // Directed FLL write with fixed ack timing, then a read.
    d1_force = 2;
    d2_force = 1;
    apb_access(1'b1, 12'h008, 32'hCAFE_0001);
    d1_force = 0;
    d2_force = 0;
    apb_access(1'b0, 12'h004, $urandom);
    d1_force = -1;
    d2_force = -1;

    // Timeout while waiting for ack, sticky flag and its clearing.
    mode = ModeNoAck;
    apb_access(1'b0, 12'h00C, $urandom);
    mode = ModeNormal;
    apb_access(1'b0, 12'h010, 32'h0);
    apb_access(1'b1, 12'h010, 32'hFFFF_FFFD);
    apb_access(1'b0, 12'h010, 32'h0);
    apb_access(1'b1, 12'h010, 32'h2);
    apb_access(1'b0, 12'h010, 32'h0);

    // Timeout while waiting for ack release.
    mode = ModeStuck;
    apb_access(1'b0, 12'h000, $urandom);
    mode = ModeStuck;
    apb_access(1'b1, 12'h004, $urandom);
    mode = ModeNormal;
    apb_access(1'b0, 12'h004, 32'h0);
    apb_access(1'b0, 12'h010, 32'h0);
    apb_access(1'b1, 12'h010, 32'h2);

    // Lock synchronisation: rises during setup, invisible in the access cycle.
    lock_val      = 1'b1;
    lock_on_setup = 1'b1;
    apb_access(1'b0, 12'h010, 32'h0);
    ref_lock = 1'b1;
    apb_access(1'b0, 12'h010, 32'h0);
    lock_val      = 1'b0;
    lock_on_setup = 1'b1;
    apb_access(1'b0, 12'h010, 32'h0);
    ref_lock = 1'b0;
    apb_access(1'b0, 12'h010, 32'h0);
    fll_lock = 1'b1;
    repeat (3) @(posedge clk);
    ref_lock = 1'b1;

    // Unmapped addresses
    apb_access(1'b0, 12'h018, 32'h0);
    apb_access(1'b1, 12'h014, 32'hFFFF_FFFF);
    apb_access(1'b1, 12'h01C, 32'h5555_AAAA);

    // Randomised traffic
    for (int n = 0; n < 80; n++) begin
      sel = 3'($urandom_range(0, 7));
      wr  = 1'($urandom);
      r   = int'($urandom_range(0, 9));
      if (!sel[2] && r == 0)      mode = ModeNoAck;
      else if (!sel[2] && r == 1) mode = ModeStuck;
      else                        mode = ModeNormal;
      apb_access(wr, {7'($urandom), sel, 2'($urandom)}, $urandom);
      mode = ModeNormal;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("req_q_drained", 64'(exp_req_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_fll_cfg.md
# apb_fll_cfg

APB slave that bridges the peripheral bus to the FLL configuration port of the clock/reset generator. It converts each APB access to one of the four FLL configuration registers into a four-phase req/ack transaction on the FLL port. It also exposes a local status register that carries a synchronised lock flag and a sticky timeout flag. It sits directly upstream of the clock/reset generator, and its fll_* outputs connect one-to-one to that block's fll_* inputs.

## Interface
- APB_ADDR_WIDTH, 12, width of PADDR; only PADDR[4:2] is decoded.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in any handshake-wait state before an access is aborted; legal range 2..65535.

Ports:
- clk_i  in  1  system clock; also the FLL reference clock, so fll_ack_i and fll_r_data_i are synchronous to it.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB write strobe (1 = write).
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready.
- PSLVERR  out  1  APB error.
- fll_req_o  out  1  FLL configuration request, registered.
- fll_wrn_o  out  1  FLL write-not (1 = read, 0 = write), registered.
- fll_add_o  out  2  FLL register index, registered.
- fll_data_o  out  32  FLL write data, registered.
- fll_ack_i  in  1  FLL acknowledge.
- fll_r_data_i  in  32  FLL read data.
- fll_lock_i  in  1  FLL lock; treated as asynchronous.

## Operation
Address map (PADDR[4:2]):
- 0..3: FLL register fll_add = PADDR[3:2].
- 4: STATUS. Bit0 = lock_sync (RO). Bit1 = timeout_sticky; read returns the flag, write of 1 clears it. Other bits read 0.
- 5..7: unmapped. PREADY=1 and PSLVERR=1 in the access cycle, PRDATA=0, no side effects.

Lock synchronisation:
- fll_lock_i passes through a 2-flop synchroniser to produce lock_sync.
- Both synchroniser flops reset to 0.

FSM states: IDLE, REQ, RELEASE, DONE.
- IDLE: on PSEL&PENABLE with an FLL address, latch wrn=~PWRITE, add=PADDR[3:2], data=PWDATA. Drive fll_req_o=1 and go to REQ. Counter cleared.
- REQ: hold req. If fll_ack_i=1, capture fll_r_data_i into rdata_q (reads only), drive fll_req_o=0, go to RELEASE, clear counter. Else increment counter.
- RELEASE: if fll_ack_i=0, go to DONE. Else increment counter.
- DONE: PREADY=1 for exactly one cycle. PSLVERR=err_q. PRDATA=rdata_q for reads, 0 for writes. Return to IDLE.
- Timeout: counter reaching TIMEOUT_CYCLES-1 in REQ or RELEASE does all of the following:
  - sets err_q and timeout_sticky;
  - forces fll_req_o=0 and rdata_q=0;
  - goes to DONE.
- err_q clears on entry to REQ.

STATUS and unmapped accesses:
- Complete combinationally in IDLE (PREADY=1 the same cycle).
- The FSM stays in IDLE.

Other rules:
- PREADY=0 whenever an FLL access is in progress: the access cycle in IDLE, REQ, and RELEASE.
- Out of IDLE, PSEL/PADDR/PWDATA are ignored (the APB master holds them stable by protocol).
- A timeout event and a STATUS write-1-to-clear in the same cycle: set wins. This is only reachable if an IDLE status access coincides, which cannot happen, but the priority is fixed regardless.

## Timing
- Reset values (registered, all 0): fll_req_o, fll_wrn_o, fll_add_o, fll_data_o, rdata_q, err_q, timeout_sticky, counter, lock_sync.
- Reset values of combinational APB outputs during reset: PREADY=0, PSLVERR=0, PRDATA=0. State = IDLE.
- Reset asserted mid-transaction: the next edge returns to IDLE with fll_req_o=0. The pending APB access is abandoned, and the master must be reset too.
- Access latency, with the access phase at cycle 0:
  - fll_req_o rises at cycle 1.
  - If ack rises at cycle a (≥1) and falls at cycle b (>a), req falls at a+1 and PREADY is high at cycle b+1.
  - Minimum FLL access = 4 cycles (a=1, b=2, PREADY at cycle 3).
- lock_sync follows fll_lock_i after 2 rising edges.
- Timeout: PREADY is high at most TIMEOUT_CYCLES+1 cycles after REQ entry per wait state.

## Test plan
- Reset: assert rst_i 3 cycles with fll_ack_i=1 -> all outputs 0, PREADY=0, state IDLE; a STATUS read afterwards returns 0x0.
- FLL write: PADDR=0x008, PWDATA=0xCAFE0001; ack high 2 cycles after req and low 1 cycle after req drops -> fll_add_o=2, fll_wrn_o=0, fll_data_o=0xCAFE0001; PREADY high exactly one cycle; PSLVERR=0.
- FLL read: PADDR=0x004, fll_r_data_i=0x12345678 valid with ack -> PRDATA=0x12345678 in the PREADY cycle, fll_wrn_o=1, fll_add_o=1.
- Timeout: TIMEOUT_CYCLES=16, ack never rises -> req drops after 16 cycles in REQ, PREADY+PSLVERR=1, PRDATA=0; STATUS read returns 0x2; STATUS write 0x2 then read returns 0x0.
- Lock sync: toggle fll_lock_i 0->1 -> STATUS bit0 is 0 on the first read within 1 cycle, and 1 on a read issued ≥2 cycles later.
- Unmapped: read PADDR=0x018 -> PREADY=1 and PSLVERR=1 in the same cycle, PRDATA=0, fll_req_o stays 0.
